// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding 16-bit reads into a one-entry decode slot,
// with branch flush of in-flight work and a saturating fetch-stall counter.
module fetch_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [15:0]      PC,
  input  logic             br,
  output logic             PC_Wen,
  output logic             mem_req,
  output logic [15:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [15:0]      mem_rdata,
  output logic             inst_valid,
  output logic [15:0]      inst,
  output logic [15:0]      inst_pc,
  input  logic             dec_ready,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_e;

  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic [15:0]      addr_q, addr_d;
  logic             valid_q, valid_d;
  logic [15:0]      inst_q, inst_d;
  logic [15:0]      inst_pc_q, inst_pc_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             slot_free;

  assign slot_free = !valid_q || dec_ready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    valid_d   = valid_q && !dec_ready;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    PC_Wen    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (br) begin
          PC_Wen  = 1'b1;
          valid_d = 1'b0;
        end else if (slot_free) begin
          addr_d  = PC;
          state_d = StReq;
        end
      end
      StReq: begin
        if (br) begin
          PC_Wen  = 1'b1;
          valid_d = 1'b0;
          state_d = mem_ack ? StIdle : StDiscard;
        end else if (mem_ack) begin
          inst_d    = mem_rdata;
          inst_pc_d = addr_q;
          valid_d   = 1'b1;
          PC_Wen    = 1'b1;
          state_d   = StIdle;
        end
      end
      StDiscard: begin
        // Wrong-path response is drained here and never reaches the slot.
        valid_d = 1'b0;
        if (br) PC_Wen = 1'b1;
        if (mem_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    req_d = (state_d == StReq) || (state_d == StDiscard);

    stall_d = stall_q;
    if (req_q && !mem_ack && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      req_q     <= 1'b0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      stall_q   <= stall_d;
    end
  end

  assign mem_req    = req_q;
  assign mem_addr   = addr_q;
  assign inst_valid = valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: PC generator and variable-latency memory models, a program-order
// scoreboard fed by branch stimulus, and directed latency/flush/reset scenarios.
module tb_fetch_unit;

  localparam int unsigned CNT_W = 4;
  localparam logic [15:0] K     = 16'hA5C3;  // memory image: word at a is a ^ K

  logic             clk = 1'b0;
  logic             resetn;
  logic [15:0]      PC;
  logic             br;
  logic [15:0]      br_target;
  logic             PC_Wen;
  logic             mem_req;
  logic [15:0]      mem_addr;
  logic             mem_ack;
  logic [15:0]      mem_rdata;
  logic             inst_valid;
  logic [15:0]      inst;
  logic [15:0]      inst_pc;
  logic             dec_ready;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int delivered = 0;
  int fixed_wait;
  int left;
  logic pending;
  logic [15:0] exp_q[$];

  fetch_unit #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .PC         (PC),
    .br         (br),
    .PC_Wen     (PC_Wen),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .dec_ready  (dec_ready),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  // PC generator: +2 on a capture pulse, branch target on a redirect pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     PC <= 16'h0000;
    else if (PC_Wen) PC <= br ? br_target : PC + 16'd2;
  end

  // Memory: per request a wait of fixed_wait cycles (random 0..3 if negative).
  always @(negedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ack   = 1'b0;
      mem_rdata = 16'h0;
      pending   = 1'b0;
      left      = 0;
    end else if (mem_req) begin
      if (!pending) begin
        pending = 1'b1;
        left    = (fixed_wait < 0) ? int'($urandom_range(0, 3)) : fixed_wait;
      end
      if (left == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_addr ^ K;
        pending   = 1'b0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
        left--;
      end
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 16'($urandom);
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs on the falling edge, then settle before checks.
  task automatic cyc(input logic b, input logic [15:0] tgt, input logic dr);
    @(negedge clk);
    br        = b;
    br_target = tgt;
    dec_ready = dr;
    if (b) begin
      exp_q.delete();
      exp_q.push_back(tgt);
    end
    #2;
  endtask

  // Monitor: program order of consumed instructions plus per-cycle protocol rules.
  initial begin
    logic [15:0]      prev_pc, prev_addr, e;
    logic             prev_cap, prev_br, prev_stall;
    logic [CNT_W-1:0] stall_m;
    prev_pc = 0; prev_addr = 0; prev_cap = 0; prev_br = 0; prev_stall = 0; stall_m = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!resetn) begin
        exp_q.delete();
        exp_q.push_back(16'h0000);
        stall_m = 0; prev_cap = 0; prev_br = 0; prev_stall = 0;
        continue;
      end
      if (br) check("pc_wen_on_br", 16'(PC_Wen), 16'd1);
      if (prev_br) check("flush_on_br", 16'(inst_valid), 16'd0);
      if (prev_cap) begin
        check("capture_valid", 16'(inst_valid), 16'd1);
        check("capture_pc", inst_pc, prev_pc);
        check("capture_data", inst, prev_pc ^ K);
      end
      if (prev_stall) begin
        check("req_held", 16'(mem_req), 16'd1);
        check("addr_stable", mem_addr, prev_addr);
      end
      check("stall_cnt", 16'(stall_cnt), 16'(stall_m));
      if (inst_valid && dec_ready && !br) begin
        if (exp_q.size() == 0) begin
          check("order_nonempty", 16'd0, 16'd1);
        end else begin
          e = exp_q.pop_front();
          check("order_pc", inst_pc, e);
          check("order_data", inst, e ^ K);
          exp_q.push_back(e + 16'd2);
          delivered++;
        end
      end
      prev_cap   = PC_Wen && !br;
      prev_br    = br;
      prev_pc    = PC;
      prev_stall = mem_req && !mem_ack;
      prev_addr  = mem_addr;
      if (mem_req && !mem_ack && stall_m != {CNT_W{1'b1}}) stall_m = stall_m + 1'b1;
    end
  end

  initial begin
    resetn = 1'b0; br = 1'b0; br_target = 16'h0; dec_ready = 1'b1; fixed_wait = 0;
    #3;
    check("rst_mem_req", 16'(mem_req), 16'd0);
    check("rst_mem_addr", mem_addr, 16'h0);
    check("rst_inst_valid", 16'(inst_valid), 16'd0);
    check("rst_inst", inst, 16'h0);
    check("rst_inst_pc", inst_pc, 16'h0);
    check("rst_stall_cnt", 16'(stall_cnt), 16'd0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Zero-wait fetch latency and sequential advance.
    cyc(1'b0, 16'h0, 1'b1);
    check("t1_req", 16'(mem_req), 16'd1);
    check("t1_addr", mem_addr, 16'h0000);
    check("t1_pc_wen", 16'(PC_Wen), 16'd1);
    cyc(1'b0, 16'h0, 1'b1);
    check("t1_valid", 16'(inst_valid), 16'd1);
    check("t1_inst_pc", inst_pc, 16'h0000);
    check("t1_req_drop", 16'(mem_req), 16'd0);
    cyc(1'b0, 16'h0, 1'b1);
    check("t1_next_req", 16'(mem_req), 16'd1);
    check("t1_next_addr", mem_addr, 16'h0002);

    // Slot fills with decode stalled, then redirect to 0 and fetch with 3 wait cycles.
    repeat (4) cyc(1'b0, 16'h0, 1'b0);
    check("t3_no_req", 16'(mem_req), 16'd0);
    check("t3_no_wen", 16'(PC_Wen), 16'd0);
    check("t3_full", 16'(inst_valid), 16'd1);
    fixed_wait = 3;
    cyc(1'b1, 16'h0000, 1'b0);
    check("t2_br_wen", 16'(PC_Wen), 16'd1);
    cyc(1'b0, 16'h0, 1'b0);
    check("t2_flushed", 16'(inst_valid), 16'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 16'h0, 1'b0);
      check("t2_req_held", 16'(mem_req), 16'd1);
      check("t2_addr", mem_addr, 16'h0000);
    end
    cyc(1'b0, 16'h0, 1'b0);
    check("t2_inst", inst, 16'hA5C3);
    check("t2_stall_cnt", 16'(stall_cnt), 16'd3);
    repeat (3) begin
      cyc(1'b0, 16'h0, 1'b0);
      check("t3_hold_req", 16'(mem_req), 16'd0);
      check("t3_hold_wen", 16'(PC_Wen), 16'd0);
    end
    cyc(1'b0, 16'h0, 1'b1);
    check("t3_release_req", 16'(mem_req), 16'd0);
    cyc(1'b0, 16'h0, 1'b1);
    check("t3_restart_req", 16'(mem_req), 16'd1);
    check("t3_restart_addr", mem_addr, 16'h0002);

    // Branch while the request is waiting: drain in DISCARD.
    cyc(1'b1, 16'h0100, 1'b1);
    check("t4_br_wen", 16'(PC_Wen), 16'd1);
    cyc(1'b0, 16'h0, 1'b1);
    check("t4_no_wen", 16'(PC_Wen), 16'd0);
    check("t4_discard_req", 16'(mem_req), 16'd1);
    check("t4_discard_addr", mem_addr, 16'h0002);
    cyc(1'b0, 16'h0, 1'b1);
    check("t4_ack", 16'(mem_ack), 16'd1);
    check("t4_ack_no_wen", 16'(PC_Wen), 16'd0);
    cyc(1'b0, 16'h0, 1'b1);
    check("t4_idle", 16'(mem_req), 16'd0);
    check("t4_dropped", 16'(inst_valid), 16'd0);
    fixed_wait = 0;

    // Branch in the same cycle as a capture ack.
    cyc(1'b1, 16'h0200, 1'b1);
    check("t5_new_addr", mem_addr, 16'h0100);
    check("t5_ack", 16'(mem_ack), 16'd1);
    check("t5_wen", 16'(PC_Wen), 16'd1);
    cyc(1'b0, 16'h0, 1'b1);
    check("t5_dropped", 16'(inst_valid), 16'd0);
    check("t5_idle", 16'(mem_req), 16'd0);
    check("t5_single_wen", 16'(PC_Wen), 16'd0);
    fixed_wait = 3;
    cyc(1'b0, 16'h0, 1'b1);
    check("t5_target_addr", mem_addr, 16'h0200);
    check("t5_stall_cnt", 16'(stall_cnt), 16'd6);

    // Asynchronous reset mid-request, before the next rising edge.
    #1 resetn = 1'b0;
    #1;
    check("t6_req", 16'(mem_req), 16'd0);
    check("t6_valid", 16'(inst_valid), 16'd0);
    check("t6_stall", 16'(stall_cnt), 16'd0);
    check("t6_addr", mem_addr, 16'h0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // Random traffic against the scoreboard.
    fixed_wait = -1;
    delivered  = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 9) == 0), 16'($urandom) & 16'hFFFE, ($urandom_range(0, 3) != 0));
    end
    cyc(1'b0, 16'h0, 1'b1);
    n_checks++;
    if (delivered < 100) begin
      n_fail++;
      $display("FAIL random_progress: got %0d deliveries, expected at least 100", delivered);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
